// File: rtl/ram_mp_arb.sv
// -----------------------------------------------------------------------------
// ram_mp_arb -- parametrised NPORT synchronous RAM with byte enables.
//
// All ports share one clock. Writes to the same address in one cycle are
// resolved in favour of the lowest-indexed port; the losers see a wr_coll
// pulse. Reads return either pre-write data (RDW_MODE=0) or the word as merged
// with the winning write (RDW_MODE=1). After reset an optional sweep writes
// INIT_VAL to every word, holding busy high and dropping requests meanwhile.
//
// Ports (port p owns bits [p*W +: W] of every packed per-port bus):
//   clk, rst_n       single clock, asynchronous active-low reset
//   req, we          per-port request and write select (1 = write)
//   be               per-port byte enables, NBE = DWID/8 bits each
//   addr, din        per-port address and write data
//   dout, dvalid     per-port read data (held) and one-cycle valid strobe
//   wr_coll          one-cycle pulse: this port's write lost arbitration
//   addr_err         one-cycle pulse: this port requested addr >= DEPTH
//   busy             high while the clear sweep runs
// -----------------------------------------------------------------------------
module ram_mp_arb #(
  parameter int              NPORT    = 2,
  parameter int              DEPTH    = 256,
  parameter int              AWID     = 8,
  parameter int              DWID     = 16,
  parameter int              RD_LAT   = 1,
  parameter int              RDW_MODE = 0,
  parameter int              CLEAR_EN = 1,
  parameter logic [DWID-1:0] INIT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORT-1:0]          req,
  input  logic [NPORT-1:0]          we,
  input  logic [NPORT*(DWID/8)-1:0] be,
  input  logic [NPORT*AWID-1:0]     addr,
  input  logic [NPORT*DWID-1:0]     din,
  output logic [NPORT*DWID-1:0]     dout,
  output logic [NPORT-1:0]          dvalid,
  output logic [NPORT-1:0]          wr_coll,
  output logic [NPORT-1:0]          addr_err,
  output logic                      busy
);

  localparam int NBE = DWID / 8;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // One extra bit so DEPTH == 2**AWID still compares correctly.
  localparam logic [AWID:0]   DEPTH_W = (AWID+1)'(DEPTH);
  localparam logic [AWID-1:0] LAST_W  = AWID'(DEPTH - 1);

  logic                  state_q, state_d;
  logic [AWID-1:0]       clr_cnt_q, clr_cnt_d;
  logic [DWID-1:0]       mem_q [DEPTH];

  logic [AWID-1:0]       addr_a [NPORT];
  logic [DWID-1:0]       din_a  [NPORT];
  logic [NBE-1:0]        be_a   [NPORT];

  logic [NPORT-1:0]      in_rng, wr_req, wr_win, rd_acc, err_d, coll_d;
  logic [DWID-1:0]       rd_data_d [NPORT];

  logic [NPORT-1:0]      s1_vld_q, coll_q, err_q;
  logic [DWID-1:0]       s1_data_q [NPORT];
  logic [DWID-1:0]       s1_data_d [NPORT];
  logic [DWID-1:0]       out_data  [NPORT];

  logic run;
  assign run  = (state_q == ST_RUN);
  assign busy = (state_q == ST_INIT);

  // Clear sweep: one word per cycle, then RUN for good until the next reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_W) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end
    end
  end

  // Request decode, arbitration and read data selection.
  always_comb begin
    in_rng = '0;
    wr_req = '0;
    rd_acc = '0;
    err_d  = '0;
    for (int p = 0; p < NPORT; p++) begin
      addr_a[p] = addr[p*AWID +: AWID];
      din_a[p]  = din[p*DWID +: DWID];
      be_a[p]   = be[p*NBE +: NBE];
      in_rng[p] = ({1'b0, addr_a[p]} < DEPTH_W);
      // A write with no byte enabled touches nothing, so it does not contend.
      wr_req[p] = run && req[p] && we[p] && in_rng[p] && (be_a[p] != '0);
      rd_acc[p] = run && req[p] && !we[p];
      err_d[p]  = run && req[p] && !in_rng[p];
    end

    // A write wins unless some lower-indexed port writes the same word.
    wr_win = wr_req;
    for (int p = 1; p < NPORT; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_req[q] && (addr_a[q] == addr_a[p])) wr_win[p] = 1'b0;
      end
    end
    coll_d = wr_req & ~wr_win;

    for (int p = 0; p < NPORT; p++) begin
      rd_data_d[p] = '0;
      if (in_rng[p]) rd_data_d[p] = mem_q[addr_a[p]];
      // Write-first: overlay the winning write's enabled bytes onto the old word.
      if (RDW_MODE == 1) begin
        for (int w = 0; w < NPORT; w++) begin
          if (wr_win[w] && in_rng[p] && (addr_a[w] == addr_a[p])) begin
            for (int b = 0; b < NBE; b++) begin
              if (be_a[w][b]) rd_data_d[p][b*8 +: 8] = din_a[w][b*8 +: 8];
            end
          end
        end
      end
      // dout holds its last value until the next accepted read.
      s1_data_d[p] = rd_acc[p] ? rd_data_d[p] : s1_data_q[p];
    end
  end

  // NOTE: the storage array has no reset; clearing is done by the sweep, which
  // keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) mem_q[clr_cnt_q] <= INIT_VAL;
    for (int p = 0; p < NPORT; p++) begin
      if (wr_win[p]) begin
        for (int b = 0; b < NBE; b++) begin
          if (be_a[p][b]) mem_q[addr_a[p]][b*8 +: 8] <= din_a[p][b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= (CLEAR_EN != 0) ? ST_INIT : ST_RUN;
      clr_cnt_q <= '0;
      s1_vld_q  <= '0;
      coll_q    <= '0;
      err_q     <= '0;
      for (int p = 0; p < NPORT; p++) s1_data_q[p] <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      s1_vld_q  <= rd_acc;
      coll_q    <= coll_d;
      err_q     <= err_d;
      for (int p = 0; p < NPORT; p++) s1_data_q[p] <= s1_data_d[p];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NPORT-1:0] s2_vld_q;
      logic [DWID-1:0]  s2_data_q [NPORT];
      logic [DWID-1:0]  s2_data_d [NPORT];

      always_comb begin
        for (int p = 0; p < NPORT; p++)
          s2_data_d[p] = s1_vld_q[p] ? s1_data_q[p] : s2_data_q[p];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_q <= '0;
          for (int p = 0; p < NPORT; p++) s2_data_q[p] <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          for (int p = 0; p < NPORT; p++) s2_data_q[p] <= s2_data_d[p];
        end
      end

      assign dvalid   = s2_vld_q;
      assign out_data = s2_data_q;
    end else begin : g_lat1
      assign dvalid   = s1_vld_q;
      assign out_data = s1_data_q;
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int p = 0; p < NPORT; p++) dout[p*DWID +: DWID] = out_data[p];
  end

  assign wr_coll  = coll_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_ram_mp_arb.sv
// -----------------------------------------------------------------------------
// tb_ram_mp_arb -- drives two ram_mp_arb instances with identical stimulus:
//   u_dut_a: DEPTH=256, RD_LAT=1, RDW_MODE=0 (read-first)
//   u_dut_b: DEPTH=200, RD_LAT=2, RDW_MODE=1 (write-first)
// A behavioural model per instance (word arrays plus a schedule of expected
// output events per cycle) is compared against every output each cycle, and
// directed scenarios add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_ram_mp_arb;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req   = '0;
  logic [1:0]  we    = '0;
  logic [3:0]  be    = '0;
  logic [15:0] addr  = '0;
  logic [31:0] din   = '0;

  logic [31:0] dout_a, dout_b;
  logic [1:0]  dvalid_a, dvalid_b, wr_coll_a, wr_coll_b, addr_err_a, addr_err_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_mp_arb #(.NPORT(2), .DEPTH(256), .AWID(8), .DWID(16), .RD_LAT(1),
               .RDW_MODE(0), .CLEAR_EN(1), .INIT_VAL(16'hA5A5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
    .din(din), .dout(dout_a), .dvalid(dvalid_a), .wr_coll(wr_coll_a),
    .addr_err(addr_err_a), .busy(busy_a));

  ram_mp_arb #(.NPORT(2), .DEPTH(200), .AWID(8), .DWID(16), .RD_LAT(2),
               .RDW_MODE(1), .CLEAR_EN(1), .INIT_VAL(16'hA5A5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
    .din(din), .dout(dout_b), .dvalid(dvalid_b), .wr_coll(wr_coll_b),
    .addr_err(addr_err_b), .busy(busy_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dep(input int i);  return (i == 0) ? 256 : 200; endfunction
  function automatic int lat(input int i);  return (i == 0) ? 1 : 2;     endfunction
  function automatic int rdw(input int i);  return (i == 0) ? 0 : 1;     endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] ben);
    logic [15:0] r;
    r = old;
    if (ben[0]) r[7:0]  = nw[7:0];
    if (ben[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  logic [15:0] m_mem  [2][256];
  int          init_left [2];
  int          cyc = 0;
  // Expected outputs, indexed by the cycle (mod 8) after whose edge they show.
  bit          sl_v [2][2][8];
  bit          sl_c [2][2][8];
  bit          sl_e [2][2][8];
  logic [15:0] sl_d [2][2][8];
  logic [15:0] last_d [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      init_left[i] = dep(i);
      for (int p = 0; p < 2; p++) begin
        last_d[i][p] = '0;
        for (int s = 0; s < 8; s++) begin
          sl_v[i][p][s] = 0; sl_c[i][p][s] = 0; sl_e[i][p][s] = 0; sl_d[i][p][s] = '0;
        end
      end
    end
  endtask

  task automatic model_step(input int i);
    int          s, sr;
    logic [7:0]  a [2];
    logic [15:0] d [2];
    logic [1:0]  b [2];
    bit          wv [2];
    bit          win [2];
    logic [15:0] rd;
    s  = cyc % 8;
    sr = (cyc + lat(i) - 1) % 8;
    if (init_left[i] > 0) begin
      init_left[i]--;
      if (init_left[i] == 0)
        for (int k = 0; k < 256; k++) m_mem[i][k] = 16'hA5A5;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      a[p]  = addr[p*8 +: 8];
      d[p]  = din[p*16 +: 16];
      b[p]  = be[p*2 +: 2];
      wv[p] = req[p] && we[p] && (int'(a[p]) < dep(i)) && (b[p] != 2'b00);
      sl_e[i][p][s] = req[p] && (int'(a[p]) >= dep(i));
    end
    for (int p = 0; p < 2; p++) begin
      win[p] = wv[p];
      for (int q = 0; q < p; q++)
        if (wv[q] && a[q] == a[p]) win[p] = 0;
      sl_c[i][p][s] = wv[p] && !win[p];
    end
    for (int p = 0; p < 2; p++) begin
      if (req[p] && !we[p]) begin
        rd = (int'(a[p]) < dep(i)) ? m_mem[i][a[p]] : 16'h0000;
        if (rdw(i) == 1)
          for (int w = 0; w < 2; w++)
            if (win[w] && a[w] == a[p] && int'(a[p]) < dep(i)) rd = merge(rd, d[w], b[w]);
        sl_v[i][p][sr] = 1;
        sl_d[i][p][sr] = rd;
      end
    end
    for (int p = 0; p < 2; p++)
      if (win[p]) m_mem[i][a[p]] = merge(m_mem[i][a[p]], d[p], b[p]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc = cyc + 1;
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle comparison of every output against the model schedule.
  always @(negedge clk) begin : chk
    int          s;
    logic [15:0] o_d;
    logic        o_v, o_c, o_e;
    string       nm;
    s = cyc % 8;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "a" : "b";
      check($sformatf("busy_%s", nm), (i == 0) ? busy_a : busy_b, (init_left[i] > 0));
      for (int p = 0; p < 2; p++) begin
        o_d = (i == 0) ? dout_a[p*16 +: 16] : dout_b[p*16 +: 16];
        o_v = (i == 0) ? dvalid_a[p]   : dvalid_b[p];
        o_c = (i == 0) ? wr_coll_a[p]  : wr_coll_b[p];
        o_e = (i == 0) ? addr_err_a[p] : addr_err_b[p];
        if (sl_v[i][p][s]) last_d[i][p] = sl_d[i][p][s];
        check($sformatf("dvalid_%s%0d", nm, p),   o_v, sl_v[i][p][s]);
        check($sformatf("dout_%s%0d", nm, p),     o_d, last_d[i][p]);
        check($sformatf("wr_coll_%s%0d", nm, p),  o_c, sl_c[i][p][s]);
        check($sformatf("addr_err_%s%0d", nm, p), o_e, sl_e[i][p][s]);
        sl_v[i][p][s] = 0; sl_c[i][p][s] = 0; sl_e[i][p][s] = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; we = '0; be = '0; addr = '0; din = '0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [7:0] a,
                          input logic [1:0] bn, input logic [15:0] d);
    req[p] = 1'b1; we[p] = w; addr[p*8 +: 8] = a; be[p*2 +: 2] = bn; din[p*16 +: 16] = d;
  endtask

  // Single read on port p; instance a answers after one edge, b after two.
  task automatic rd_chk(input string tag, input int p, input logic [7:0] a,
                        input logic [15:0] ea, input logic [15:0] eb);
    idle();
    set_port(p, 1'b0, a, 2'b00, 16'h0);
    tick();
    idle();
    check({tag, "_va"}, dvalid_a[p], 1'b1);
    check({tag, "_da"}, dout_a[p*16 +: 16], ea);
    check({tag, "_vb_early"}, dvalid_b[p], 1'b0);
    tick();
    check({tag, "_va_drop"}, dvalid_a[p], 1'b0);
    check({tag, "_vb"}, dvalid_b[p], 1'b1);
    check({tag, "_db"}, dout_b[p*16 +: 16], eb);
  endtask

  task automatic measure_busy(input string tag);
    int na, nb;
    na = -1; nb = -1;
    for (int k = 1; k <= 400 && (na < 0 || nb < 0); k++) begin
      tick();
      if (na < 0 && !busy_a) na = k;
      if (nb < 0 && !busy_b) nb = k;
    end
    check({tag, "_a"}, na, 256);
    check({tag, "_b"}, nb, 200);
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 8'($urandom_range(0, 7));
    if (r < 7) return 8'($urandom_range(195, 205));
    if (r < 8) return 8'($urandom_range(248, 255));
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    measure_busy("busy_len");

    rd_chk("init0", 0, 8'd0, 16'hA5A5, 16'hA5A5);
    rd_chk("init255", 0, 8'd255, 16'hA5A5, 16'h0000);

    // Same-address write collision: port0 wins, port1 flags wr_coll.
    idle();
    set_port(0, 1'b1, 8'd5, 2'b11, 16'h1234);
    set_port(1, 1'b1, 8'd5, 2'b11, 16'hFFFF);
    tick();
    idle();
    check("coll_a", wr_coll_a, 2'b10);
    check("coll_b", wr_coll_b, 2'b10);
    tick();
    check("coll_a_drop", wr_coll_a, 2'b00);
    rd_chk("coll_rd", 0, 8'd5, 16'h1234, 16'h1234);

    // Read-during-write on addr 9 with a low-byte write.
    idle();
    set_port(0, 1'b1, 8'd9, 2'b01, 16'h00CC);
    set_port(1, 1'b0, 8'd9, 2'b00, 16'h0000);
    tick();
    idle();
    check("rdw_va", dvalid_a[1], 1'b1);
    check("rdw_da", dout_a[31:16], 16'hA5A5);
    tick();
    check("rdw_vb", dvalid_b[1], 1'b1);
    check("rdw_db", dout_b[31:16], 16'hA5CC);
    rd_chk("rdw_rd", 1, 8'd9, 16'hA5CC, 16'hA5CC);

    // Back-to-back reads of 1,2,3 on port1.
    idle();
    set_port(0, 1'b1, 8'd1, 2'b11, 16'h1111);
    set_port(1, 1'b1, 8'd2, 2'b11, 16'h2222);
    tick();
    idle();
    set_port(0, 1'b1, 8'd3, 2'b11, 16'h3333);
    tick();
    idle();
    set_port(1, 1'b0, 8'd1, 2'b00, 16'h0);
    tick();
    check("b2b_vb0", dvalid_b[1], 1'b0);
    set_port(1, 1'b0, 8'd2, 2'b00, 16'h0);
    tick();
    check("b2b_vb1", dvalid_b[1], 1'b1);
    check("b2b_db1", dout_b[31:16], 16'h1111);
    set_port(1, 1'b0, 8'd3, 2'b00, 16'h0);
    tick();
    idle();
    check("b2b_vb2", dvalid_b[1], 1'b1);
    check("b2b_db2", dout_b[31:16], 16'h2222);
    tick();
    check("b2b_vb3", dvalid_b[1], 1'b1);
    check("b2b_db3", dout_b[31:16], 16'h3333);
    tick();
    check("b2b_vb4", dvalid_b[1], 1'b0);

    // Address 250: in range for a, out of range for b.
    idle();
    set_port(0, 1'b1, 8'd250, 2'b11, 16'hBEEF);
    tick();
    idle();
    check("oor_err_b_wr", addr_err_b, 2'b01);
    check("oor_err_a_wr", addr_err_a, 2'b00);
    set_port(0, 1'b0, 8'd250, 2'b00, 16'h0);
    tick();
    idle();
    check("oor_err_b_rd", addr_err_b, 2'b01);
    check("oor_da", dout_a[15:0], 16'hBEEF);
    tick();
    check("oor_err_b_drop", addr_err_b, 2'b00);
    check("oor_vb", dvalid_b[0], 1'b1);
    check("oor_db", dout_b[15:0], 16'h0000);

    // Write with no byte enabled is a no-op.
    idle();
    set_port(0, 1'b1, 8'd7, 2'b00, 16'hFFFF);
    tick();
    idle();
    check("be0_err", addr_err_a, 2'b00);
    rd_chk("be0_rd", 0, 8'd7, 16'hA5A5, 16'hA5A5);

    // Randomised traffic, checked by the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      idle();
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 9) < 7)
          set_port(p, 1'($urandom_range(0, 1)), rand_addr(),
                   2'($urandom_range(1, 3)), 16'($urandom));
      end
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset mid-sweep at count 100: the sweep restarts from word 0.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    measure_busy("busy_len_restart");

    for (int k = 0; k < 128; k++) begin
      idle();
      set_port(0, 1'b0, 8'(2*k), 2'b00, 16'h0);
      set_port(1, 1'b0, 8'(2*k + 1), 2'b00, 16'h0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
